dispatch_skid_queue: RTL and testbench
======================================

// Module: dispatch_skid_queue
// PURPOSE
//  Parametrised successor to the single-slot decode/rename pipeline register. It is a DEPTH-entry
//  in-order FIFO between rename and reservation-station dispatch, with a valid/ready handshake
//  in place of stall. Each entry snoops the CDB and wakes up its pending source operands while
//  it waits, so no tag goes stale in the buffer. Flush clears the whole queue in one cycle.
// PARAMETERS
//  PAYLOAD_W  128  opaque decoded fields (pc, alu/mem/br/csr op, imm, rd, alloc_rob); never interpreted
//  DEPTH      2    entry count, >=1, power of two; 2 gives full throughput
//  TAG_W      3    ROB tag width, = $clog2(`ROB_DEPTH)
//  DATA_W     32   operand value width, = `WORD_WIDTH
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          asynchronous, active-low reset
//  cpu_en       in   1          global enable; gates push, pop and flush
//  flush        in   1          discard all entries (mispredict/trap)
//  in_valid     in   1          rename offers an instruction
//  in_ready     out  1          queue can accept
//  in_payload   in   PAYLOAD_W  decoded fields
//  in_rsN_pend  in   1          N=1,2: operand waits on ROB tag (RAT valid)
//  in_rsN_tag   in   TAG_W      producer ROB tag
//  in_rsN_val   in   DATA_W     GPR value, used when not pending
//  cdb_valid    in   1          result broadcast this cycle
//  cdb_tag      in   TAG_W      broadcasting ROB tag
//  cdb_data     in   DATA_W     broadcast value
//  out_valid    out  1          head entry present
//  out_ready    in   1          dispatch accepts head
//  out_payload  out  PAYLOAD_W  head fields
//  out_rsN_pend out  1          head operand still pending
//  out_rsN_tag  out  TAG_W      head operand tag
//  out_rsN_val  out  DATA_W     head operand value
//  count        out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptr=0, all entry valid=0, all stored fields 0. Hence out_valid=0,
//    out_* =0 and in_ready=1.
//  - in_ready = (count!=DEPTH). It is a function of state only; out_ready never reaches it
//    combinationally.
//  - push = cpu_en & in_valid & in_ready. pop = cpu_en & out_valid & out_ready.
//  - Both are legal in the same cycle: count is unchanged and both pointers advance modulo DEPTH.
//  - out_* is a mux of the head entry's registers. There is no combinational path from in_* or
//    cdb_* to out_*.
//  - Latency: a push into an empty queue at edge t gives out_valid=1 after t.
//    DEPTH=1 sustains only 1 instruction per 2 cycles.
//  - Wakeup, per stored operand, every cycle, NOT gated by cpu_en:
//    if pend & cdb_valid & tag==cdb_tag then pend<=0 and val<=cdb_data.
//    tag is kept. A non-pending operand is never modified.
//  - Push-cycle bypass: if in_rsN_pend & cdb_valid & in_rsN_tag==cdb_tag, store pend=0 and
//    val=cdb_data. Otherwise store the inputs unchanged.
//  - Head in the same cycle as a matching CDB: out_rsN_pend still shows 1. The entry updates at
//    the edge. If it pops on that edge, the wakeup is dropped; the RS snoops the CDB itself.
//  - Flush: when cpu_en=1 it has priority over push and pop. After the edge: count=0, ptrs=0,
//    all valid=0, head fields zeroed (out_*=0). in_valid that cycle is ignored.
//  - cpu_en=0: no push, pop or flush. count, ptrs and payloads hold; wakeup still applies.
//  - Async reset mid-operation returns to the reset state immediately.
//  - Pointer wrap: rd/wr ptr are $clog2(DEPTH) bits and wrap naturally; full/empty come from
//    count, not pointer compare.
// STRUCTURE
//  - Shared defines package: `ROB_DEPTH, `WORD_WIDTH, tag-width macro, payload field-pack
//    macros/offsets for PAYLOAD_W.
//  - Sub-module dsq_operand_slot: one pending/tag/value register with wakeup and write-port
//    bypass. Instantiate 2*DEPTH times.
//  - Top: pointers, count, flush, head mux.
// TESTING
//  1. Reset, idle: in_ready=1, out_valid=0, count=0, out_payload=0.
//  2. Push A,B back-to-back, out_ready=0:
//     - after 2 edges count=2, in_ready=0.
//     - push C is refused and not stored.
//     - out_ready=1 gives A then B, 1 per cycle.
//  3. Streaming, DEPTH=2, in_valid=out_ready=1 for 20 cycles:
//     - 1 instruction per cycle.
//     - order preserved.
//     - count stays 1.
//  4. Entry rs1_pend=1 tag=5 stored, then cdb tag=5 data=0xDEADBEEF: next cycle out_rs1_pend=0,
//     out_rs1_val=0xDEADBEEF. cdb tag=4 has no effect.
//  5. Push with in_rs2_tag=3, pend=1 in the same cycle as cdb tag=3 data=0x11: stored pend=0,
//     val=0x11.
//  6. Full queue, flush=1 with in_valid=1 and out_ready=1:
//     - next cycle count=0, out_valid=0.
//     - nothing is popped or pushed.
//     - same stimulus with cpu_en=0 leaves state unchanged.

Source files
------------

// File: rtl/dispatch_skid_queue_pkg.sv
// Shared widths and decoded-payload layout for the rename-to-dispatch queue.
// The macros keep the older `ROB_DEPTH / `WORD_WIDTH spelling available to legacy files.
`ifndef DSQ_DEFINES_SVH
`define DSQ_DEFINES_SVH
`define ROB_DEPTH 8
`define WORD_WIDTH 32
`define DSQ_TAG_W $clog2(`ROB_DEPTH)
`endif

package dispatch_skid_queue_pkg;

    localparam int DSQ_ROB_DEPTH = `ROB_DEPTH;
    localparam int DSQ_DATA_W    = `WORD_WIDTH;
    localparam int DSQ_TAG_W     = `DSQ_TAG_W;
    localparam int DSQ_PAYLOAD_W = 128;

    // Field widths inside the opaque payload; the queue itself never looks at them.
    localparam int PL_PC_W    = 32;
    localparam int PL_IMM_W   = 32;
    localparam int PL_ALU_W   = 5;
    localparam int PL_MEM_W   = 4;
    localparam int PL_BR_W    = 3;
    localparam int PL_CSR_W   = 3;
    localparam int PL_RD_W    = 5;
    localparam int PL_USED_W  = PL_PC_W + PL_IMM_W + PL_ALU_W + PL_MEM_W + PL_BR_W
                              + PL_CSR_W + PL_RD_W + DSQ_TAG_W;
    localparam int PL_RSVD_W  = DSQ_PAYLOAD_W - PL_USED_W;

    typedef struct packed {
        logic [PL_RSVD_W-1:0] rsvd;
        logic [PL_PC_W-1:0]   pc;
        logic [PL_IMM_W-1:0]  imm;
        logic [PL_ALU_W-1:0]  alu_op;
        logic [PL_MEM_W-1:0]  mem_op;
        logic [PL_BR_W-1:0]   br_op;
        logic [PL_CSR_W-1:0]  csr_op;
        logic [PL_RD_W-1:0]   rd;
        logic [DSQ_TAG_W-1:0] alloc_rob;
    } dsq_payload_t;

    function automatic logic wake_hit(input logic pend, input logic cdb_valid,
                                      input logic tag_match);
        return pend & cdb_valid & tag_match;
    endfunction

endpackage

// File: rtl/dsq_operand_slot.sv
// One source-operand register (pending flag, producer tag, value) that snoops the CDB
// while it waits and captures a same-cycle broadcast on its write port.
module dsq_operand_slot
    import dispatch_skid_queue_pkg::*;
#(
    parameter int TAG_W  = DSQ_TAG_W,
    parameter int DATA_W = DSQ_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic              in_pend_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    input  logic [DATA_W-1:0] in_val_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              pend_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] val_o
);

    logic              pend_q, pend_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              hit_in, hit_q;

    always_comb begin
        hit_in = wake_hit(in_pend_i, cdb_valid_i, in_tag_i == cdb_tag_i);
        hit_q  = wake_hit(pend_q, cdb_valid_i, tag_q == cdb_tag_i);
        pend_d = pend_q;
        tag_d  = tag_q;
        val_d  = val_q;
        if (clr_i) begin
            pend_d = 1'b0;
            tag_d  = '0;
            val_d  = '0;
        end else if (wr_i) begin
            // A broadcast in the push cycle would otherwise be missed forever.
            pend_d = in_pend_i & ~hit_in;
            tag_d  = in_tag_i;
            val_d  = hit_in ? cdb_data_i : in_val_i;
        end else if (hit_q) begin
            pend_d = 1'b0;
            val_d  = cdb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            tag_q  <= '0;
            val_q  <= '0;
        end else begin
            pend_q <= pend_d;
            tag_q  <= tag_d;
            val_q  <= val_d;
        end
    end

    assign pend_o = pend_q;
    assign tag_o  = tag_q;
    assign val_o  = val_q;

endmodule

// File: rtl/dispatch_skid_queue.sv
// DEPTH-entry in-order queue between rename and dispatch with valid/ready handshake,
// per-entry CDB wakeup and single-cycle flush. Outputs come straight from entry registers.
module dispatch_skid_queue
    import dispatch_skid_queue_pkg::*;
#(
    parameter int PAYLOAD_W = DSQ_PAYLOAD_W,
    parameter int DEPTH     = 2,
    parameter int TAG_W     = DSQ_TAG_W,
    parameter int DATA_W    = DSQ_DATA_W,
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_en,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_rs1_pend,
    input  logic [TAG_W-1:0]     in_rs1_tag,
    input  logic [DATA_W-1:0]    in_rs1_val,
    input  logic                 in_rs2_pend,
    input  logic [TAG_W-1:0]     in_rs2_tag,
    input  logic [DATA_W-1:0]    in_rs2_val,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_rs1_pend,
    output logic [TAG_W-1:0]     out_rs1_tag,
    output logic [DATA_W-1:0]    out_rs1_val,
    output logic                 out_rs2_pend,
    output logic [TAG_W-1:0]     out_rs2_tag,
    output logic [DATA_W-1:0]    out_rs2_val,
    output logic [CNT_W-1:0]     count
);

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DEPTH-1:0]     valid_q;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];

    logic                 rs1_pend [DEPTH];
    logic [TAG_W-1:0]     rs1_tag  [DEPTH];
    logic [DATA_W-1:0]    rs1_val  [DEPTH];
    logic                 rs2_pend [DEPTH];
    logic [TAG_W-1:0]     rs2_tag  [DEPTH];
    logic [DATA_W-1:0]    rs2_val  [DEPTH];

    logic push, pop, flush_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends on occupancy only, so out_ready never ripples back to rename.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = valid_q[rd_ptr_q];
    assign flush_en  = cpu_en & flush;
    assign push      = cpu_en & ~flush & in_valid & in_ready;
    assign pop       = cpu_en & ~flush & out_valid & out_ready;

    always_comb begin
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) payload_q[i] <= '0;
        end else if (flush_en) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) payload_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            // Push and pop never target the same slot: both need 0 < count < DEPTH.
            if (pop) valid_q[rd_ptr_q] <= 1'b0;
            if (push) begin
                valid_q[wr_ptr_q]   <= 1'b1;
                payload_q[wr_ptr_q] <= in_payload;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic wr_slot;
        assign wr_slot = push & (wr_ptr_q == PTR_W'(g));

        dsq_operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs1 (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (flush_en),
            .wr_i       (wr_slot),
            .in_pend_i  (in_rs1_pend),
            .in_tag_i   (in_rs1_tag),
            .in_val_i   (in_rs1_val),
            .cdb_valid_i(cdb_valid),
            .cdb_tag_i  (cdb_tag),
            .cdb_data_i (cdb_data),
            .pend_o     (rs1_pend[g]),
            .tag_o      (rs1_tag[g]),
            .val_o      (rs1_val[g])
        );

        dsq_operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_rs2 (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (flush_en),
            .wr_i       (wr_slot),
            .in_pend_i  (in_rs2_pend),
            .in_tag_i   (in_rs2_tag),
            .in_val_i   (in_rs2_val),
            .cdb_valid_i(cdb_valid),
            .cdb_tag_i  (cdb_tag),
            .cdb_data_i (cdb_data),
            .pend_o     (rs2_pend[g]),
            .tag_o      (rs2_tag[g]),
            .val_o      (rs2_val[g])
        );
    end

    assign out_payload  = payload_q[rd_ptr_q];
    assign out_rs1_pend = rs1_pend[rd_ptr_q];
    assign out_rs1_tag  = rs1_tag[rd_ptr_q];
    assign out_rs1_val  = rs1_val[rd_ptr_q];
    assign out_rs2_pend = rs2_pend[rd_ptr_q];
    assign out_rs2_tag  = rs2_tag[rd_ptr_q];
    assign out_rs2_val  = rs2_val[rd_ptr_q];
    assign count        = count_q;

endmodule

// File: tb/tb_dispatch_skid_queue.sv
// Directed bench for dispatch_skid_queue (DEPTH=2): handshake, ordering, wakeup,
// push-cycle bypass, flush priority, cpu_en gating and asynchronous reset.
module tb_dispatch_skid_queue;

    localparam int PAYLOAD_W = 128;
    localparam int DEPTH     = 2;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cpu_en;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_rs1_pend, in_rs2_pend;
    logic [TAG_W-1:0]     in_rs1_tag, in_rs2_tag;
    logic [DATA_W-1:0]    in_rs1_val, in_rs2_val;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_rs1_pend, out_rs2_pend;
    logic [TAG_W-1:0]     out_rs1_tag, out_rs2_tag;
    logic [DATA_W-1:0]    out_rs1_val, out_rs2_val;
    logic [CNT_W-1:0]     count;

    int n_checks = 0;
    int n_errors = 0;

    dispatch_skid_queue #(
        .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_en      (cpu_en),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_rs1_pend (in_rs1_pend),
        .in_rs1_tag  (in_rs1_tag),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_pend (in_rs2_pend),
        .in_rs2_tag  (in_rs2_tag),
        .in_rs2_val  (in_rs2_val),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_rs1_pend(out_rs1_pend),
        .out_rs1_tag (out_rs1_tag),
        .out_rs1_val (out_rs1_val),
        .out_rs2_pend(out_rs2_pend),
        .out_rs2_tag (out_rs2_tag),
        .out_rs2_val (out_rs2_val),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cpu_en = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_payload = '0; out_ready = 1'b0;
        in_rs1_pend = 1'b0; in_rs1_tag = '0; in_rs1_val = '0;
        in_rs2_pend = 1'b0; in_rs2_tag = '0; in_rs2_val = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

        // Reset / idle
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_payload", out_payload, 0);
        rst_n = 1'b1;
        step();
        check("idle_count", count, 0);

        // Fill A,B with out_ready low, C refused, then drain in order
        in_valid = 1'b1; in_payload = 128'hA;
        step();
        check("pushA_count", count, 1);
        check("pushA_out_valid", out_valid, 1);
        check("pushA_head", out_payload, 128'hA);
        in_payload = 128'hB;
        step();
        check("pushB_count", count, 2);
        check("pushB_in_ready", in_ready, 0);
        in_payload = 128'hC;
        step();
        check("refuseC_count", count, 2);
        check("refuseC_head", out_payload, 128'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        check("drain_head_A", out_payload, 128'hA);
        step();
        check("drain_head_B", out_payload, 128'hB);
        check("drain_count1", count, 1);
        step();
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_count", count, 0);

        // Streaming: one in, one out every cycle, order kept, occupancy 1
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_payload = 128'(100 + i);
            step();
            check("stream_count", count, 1);
            check("stream_head", out_payload, 128'(100 + i));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_count", count, 0);

        // Wakeup of a stored pending operand
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 128'h44;
        in_rs1_pend = 1'b1; in_rs1_tag = 3'd5; in_rs1_val = 32'h123;
        in_rs2_pend = 1'b0; in_rs2_tag = 3'd5; in_rs2_val = 32'h777;
        step();
        in_valid = 1'b0;
        check("wk_stored_pend", out_rs1_pend, 1);
        check("wk_stored_tag", out_rs1_tag, 5);
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'h55;
        step();
        check("wk_other_tag_pend", out_rs1_pend, 1);
        check("wk_other_tag_val", out_rs1_val, 32'h123);
        cdb_tag = 3'd5; cdb_data = 32'hDEADBEEF;
        #1;
        check("wk_same_cycle_pend", out_rs1_pend, 1);
        step();
        cdb_valid = 1'b0;
        check("wk_pend", out_rs1_pend, 0);
        check("wk_val", out_rs1_val, 32'hDEADBEEF);
        check("wk_tag_kept", out_rs1_tag, 5);
        check("wk_nonpend_val", out_rs2_val, 32'h777);
        check("wk_nonpend_pend", out_rs2_pend, 0);

        // Push-cycle bypass while popping the previous head
        in_valid = 1'b1; out_ready = 1'b1; in_payload = 128'h55;
        in_rs1_pend = 1'b1; in_rs1_tag = 3'd6; in_rs1_val = 32'h66;
        in_rs2_pend = 1'b1; in_rs2_tag = 3'd3; in_rs2_val = 32'h99;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h11;
        step();
        in_valid = 1'b0; out_ready = 1'b0; cdb_valid = 1'b0;
        check("byp_count", count, 1);
        check("byp_head", out_payload, 128'h55);
        check("byp_rs2_pend", out_rs2_pend, 0);
        check("byp_rs2_val", out_rs2_val, 32'h11);
        check("byp_rs2_tag", out_rs2_tag, 3);
        check("byp_rs1_pend", out_rs1_pend, 1);
        check("byp_rs1_val", out_rs1_val, 32'h66);
        out_ready = 1'b1;
        step();
        check("byp_drain_count", count, 0);

        // Fill, then flush gated by cpu_en, then flush with priority
        out_ready = 1'b0; in_valid = 1'b1; in_payload = 128'hF0;
        in_rs1_pend = 1'b1; in_rs1_tag = 3'd2; in_rs1_val = 32'h0;
        in_rs2_pend = 1'b0;
        step();
        in_payload = 128'hF1; in_rs1_pend = 1'b0;
        step();
        check("fl_full_count", count, 2);
        cpu_en = 1'b0; flush = 1'b1; in_valid = 1'b1; in_payload = 128'hF2; out_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'hAB;
        step();
        cdb_valid = 1'b0;
        check("dis_count", count, 2);
        check("dis_out_valid", out_valid, 1);
        check("dis_head", out_payload, 128'hF0);
        check("dis_wake_pend", out_rs1_pend, 0);
        check("dis_wake_val", out_rs1_val, 32'hAB);
        cpu_en = 1'b1;
        step();
        check("fl_count", count, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_payload", out_payload, 0);
        check("fl_rs1_val", out_rs1_val, 0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_after_count", count, 0);
        in_valid = 1'b1; in_payload = 128'hE1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("fl_repush_count", count, 1);
        check("fl_repush_head", out_payload, 128'hE1);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_payload", out_payload, 0);
        #1 rst_n = 1'b1;
        step();
        check("arst_after_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
